level_delay_mc: RTL

//  Multi-channel, parametrised level delay/debounce. Each channel qualifies its enable level:
//   - the output asserts only after enable has been held high for rise_dly cycles;
//   - the output deasserts only after enable has been held low for fall_dly cycles.

---
 rtl/level_delay_mc_if.sv | 23 ++
 rtl/level_delay_mc.sv | 122 ++++++++++++
 2 files changed

// File: rtl/level_delay_mc_if.sv
// Per-channel level-qualifier bus: raw enables and delay fields in, qualified levels and pulses out.
interface level_delay_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*CNT_W-1:0] rise_dly;
  logic [NUM_CH*CNT_W-1:0] fall_dly;
  logic [NUM_CH-1:0]       delayed_en;
  logic [NUM_CH-1:0]       rise_pulse;
  logic [NUM_CH-1:0]       fall_pulse;
  logic [NUM_CH-1:0]       busy;

  modport master (
    output enable, rise_dly, fall_dly,
    input  delayed_en, rise_pulse, fall_pulse, busy
  );

  modport slave (
    input  enable, rise_dly, fall_dly,
    output delayed_en, rise_pulse, fall_pulse, busy
  );
endinterface

// File: rtl/level_delay_mc.sv
// Multi-channel level delay/debounce: each channel asserts after rise_dly held-high cycles
// and deasserts after fall_dly held-low cycles, filtering shorter pulses and gaps.
module level_delay_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter bit FALL_DLY_EN = 1'b1
) (
  input  logic              clk_core,
  input  logic              rst_core_n,
  level_delay_mc_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_ON        = 2'd2,
    ST_FALL_WAIT = 2'd3
  } state_e;

  logic [NUM_CH-1:0] delayed_en_vec;
  logic [NUM_CH-1:0] rise_pulse_vec;
  logic [NUM_CH-1:0] fall_pulse_vec;
  logic [NUM_CH-1:0] busy_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rise_v, fall_v;
    logic             delayed_en_q, delayed_en_d;
    logic             rise_pulse_q, rise_pulse_d;
    logic             fall_pulse_q, fall_pulse_d;
    logic             busy_q, busy_d;

    assign rise_v = bus.rise_dly[i*CNT_W +: CNT_W];
    assign fall_v = FALL_DLY_EN ? bus.fall_dly[i*CNT_W +: CNT_W] : '0;

    // The >= compare lets delays change mid-count and keeps cnt from ever wrapping.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_OFF: begin
          if (bus.enable[i]) begin
            if (rise_v == '0) begin
              state_d = ST_ON;
            end else begin
              state_d = ST_RISE_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_RISE_WAIT: begin
          if (!bus.enable[i]) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (cnt_q >= rise_v) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_ON: begin
          if (!bus.enable[i]) begin
            if (fall_v == '0) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_FALL_WAIT;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        default: begin
          if (bus.enable[i]) begin
            state_d = ST_ON;
            cnt_d   = '0;
          end else if (cnt_q >= fall_v) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase

      // Outputs are decoded from the next state so they are plain flops.
      delayed_en_d = (state_d == ST_ON) || (state_d == ST_FALL_WAIT);
      busy_d       = (state_d == ST_RISE_WAIT) || (state_d == ST_FALL_WAIT);
      rise_pulse_d = delayed_en_d & ~delayed_en_q;
      fall_pulse_d = ~delayed_en_d & delayed_en_q;
    end

    always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
        state_q      <= ST_OFF;
        cnt_q        <= '0;
        delayed_en_q <= 1'b0;
        rise_pulse_q <= 1'b0;
        fall_pulse_q <= 1'b0;
        busy_q       <= 1'b0;
      end else begin
        state_q      <= state_d;
        cnt_q        <= cnt_d;
        delayed_en_q <= delayed_en_d;
        rise_pulse_q <= rise_pulse_d;
        fall_pulse_q <= fall_pulse_d;
        busy_q       <= busy_d;
      end
    end

    assign delayed_en_vec[i] = delayed_en_q;
    assign rise_pulse_vec[i] = rise_pulse_q;
    assign fall_pulse_vec[i] = fall_pulse_q;
    assign busy_vec[i]       = busy_q;
  end

  assign bus.delayed_en = delayed_en_vec;
  assign bus.rise_pulse = rise_pulse_vec;
  assign bus.fall_pulse = fall_pulse_vec;
  assign bus.busy       = busy_vec;

endmodule
